control_seq: RTL and testbench
==============================

// Module: control_seq
// PURPOSE
//  Multi-cycle sequencer that runs after the combinational decoder in the NPC core.
//  Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, then retires it.
//  Waits for the instruction fetch unit (IFU), memory and mul/div to finish before committing.
//  Gates all architectural writes (register file, CSR, PC) to a single-cycle commit pulse.
//  Adds bus-error detection on a memory timeout, a sticky halt, and a retired-instruction counter.
// PARAMETERS
//  MUL_CYCLES   3    EXEC cycles for mul/mulw (>=1)
//  DIV_CYCLES   34   EXEC cycles for div/rem variants (>=1)
//  MEM_TIMEOUT  255  max MEM wait cycles before bus error; 0 = no timeout
//  CNT_W        64   width of the retired-instruction counter
// PORTS
//  clk          in   1      clock; all state changes on rising edge
//  rst          in   1      synchronous, active-high reset
//  ifu_req      out  1      fetch request, high in FETCH
//  ifu_rdy      in   1      instruction valid; sampled only in FETCH
//  dec_legal    in   1      decoder matched a known instruction
//  dec_rf_wen   in   1      instruction writes the register file
//  dec_csr      in   1      csrrw/csrrs
//  dec_load     in   1      any load
//  dec_store    in   1      any store
//  dec_mul      in   1      mul/mulw
//  dec_div      in   1      div/divu/rem/remu and W forms
//  dec_trap     in   1      ecall/mret
//  dec_halt     in   1      ebreak
//  mem_req      out  1      memory request, held high in MEM
//  mem_wen      out  1      store qualifier, valid while mem_req=1
//  mem_ack      in   1      memory done
//  rf_wen       out  1      register-file write commit pulse
//  c_wen        out  1      CSR write commit pulse
//  pc_wen       out  1      PC update pulse
//  trap_vld     out  1      trap commit pulse
//  trap_cause   out  2      01 illegal, 10 ecall/mret, 11 bus error
//  busy         out  1      high in any state except FETCH and HALT
//  halted       out  1      high in HALT
//  retired      out  CNT_W  retired-instruction count
//  state_o      out  3      current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, HALT=6
// BEHAVIOUR
//  Reset:
//  - Every output is 0 during the reset cycle.
//  - state=FETCH, cnt=0, retired=0; the decode flag register is cleared.
//  - The first cycle after reset deasserts is FETCH with ifu_req=1.
//  - Reset mid-operation aborts the instruction: no commit pulse, retired unchanged.
//  FETCH:
//  - ifu_req=1; stay until ifu_rdy=1, then go to DECODE.
//  - ifu_rdy in any other state is ignored.
//  DECODE (exactly 1 cycle):
//  - Register all dec_* flags. The registered copy drives every later state.
//  - Next state, in priority order: !dec_legal -> TRAP(01); dec_halt -> HALT; dec_trap -> TRAP(10); otherwise EXEC.
//  EXEC:
//  - On entry, load cnt with MUL_CYCLES-1 (mul), DIV_CYCLES-1 (div), or 0 (all others).
//  - Stay while cnt!=0, decrementing once per cycle.
//  - When cnt=0: go to MEM if load or store, otherwise WB.
//  - EXEC lasts exactly N cycles, where N is MUL_CYCLES, DIV_CYCLES, or 1.
//  MEM:
//  - mem_req=1 and mem_wen=store, held stable until exit.
//  - cnt counts up from 0. Exit to WB on mem_ack.
//  - If cnt==MEM_TIMEOUT-1 and mem_ack=0, exit to TRAP(11).
//  - If mem_ack arrives in the same cycle the timeout is reached, the ack wins (go to WB).
//  - A mem_ack on the first MEM cycle gives 1-cycle MEM.
//  WB (1 cycle):
//  - rf_wen = registered dec_rf_wen; c_wen = registered dec_csr; pc_wen=1.
//  - retired increments by 1 and wraps silently at 2^CNT_W.
//  - Go to FETCH.
//  TRAP (1 cycle):
//  - trap_vld=1, pc_wen=1, trap_cause valid; rf_wen=0 and c_wen=0.
//  - retired increments only for cause 10; it does not increment for illegal or bus error.
//  - Go to FETCH.
//  HALT:
//  - Sticky; all pulses are 0 and halted=1. Only rst leaves HALT.
//  General rules:
//  - rf_wen, c_wen, pc_wen and trap_vld are never high for more than 1 cycle per instruction.
//  - Minimum latency per ALU op is 4 cycles (FETCH, DECODE, EXEC, WB) with ifu_rdy high in FETCH.
//  - Encodings 7 and any undefined state recover to FETCH on the next edge.
// TESTING
//  - add, ifu_rdy=1 at FETCH: state 0,1,2,4,0; rf_wen=1 only in cycle 4; retired 0->1.
//  - mul, MUL_CYCLES=3: exactly 3 EXEC cycles; div, DIV_CYCLES=34: exactly 34 EXEC cycles; one rf_wen each.
//  - lw, mem_ack after 5 cycles: mem_req high for 5 cycles, mem_wen=0, then WB with rf_wen=1.
//  - sd, no ack, MEM_TIMEOUT=8: 8 MEM cycles, then trap_vld=1, trap_cause=11, rf_wen=0, retired unchanged.
//  - mem_ack on the timeout cycle: no trap, WB taken.
//  - dec_legal=0 -> TRAP(01); ecall -> TRAP(10) with retired+1.
//  - ebreak -> halted=1 held 100 cycles; rst=1 for 1 cycle -> FETCH, retired=0.
//  - rst asserted mid-EXEC of div: no rf_wen pulse; FETCH one cycle after reset deasserts.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP/HALT).
// Waits on the fetch unit, the multi-cycle EXEC units and memory. Architectural
// writes leave only as single-cycle commit pulses from WB or TRAP.
module control_seq #(
    parameter int MUL_CYCLES  = 3,
    parameter int DIV_CYCLES  = 34,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_rdy,
    input  logic             dec_legal,
    input  logic             dec_rf_wen,
    input  logic             dec_csr,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_mul,
    input  logic             dec_div,
    input  logic             dec_trap,
    input  logic             dec_halt,
    output logic             mem_req,
    output logic             mem_wen,
    input  logic             mem_ack,
    output logic             rf_wen,
    output logic             c_wen,
    output logic             pc_wen,
    output logic             trap_vld,
    output logic [1:0]       trap_cause,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // Decode flags that later states still need after DECODE has passed.
    typedef struct packed {
        logic rf_wen;
        logic csr;
        logic load;
        logic store;
    } dec_t;

    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_ENV = 2'b10;
    localparam logic [1:0] CAUSE_BUS = 2'b11;

    // One shared counter serves both the EXEC countdown and the MEM wait count.
    localparam int MAX_A = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MAX_C = (MAX_A > MEM_TIMEOUT) ? MAX_A : MEM_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    dec_t             dec_q, dec_d;
    logic [1:0]       cause_q, cause_d;

    // State register with synchronous reset; an aborted instruction leaves no trace.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            retired_q <= '0;
            dec_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            dec_q     <= dec_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state, counter, decode-capture and retire-count logic.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        dec_d     = dec_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                if (ifu_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                dec_d = '{rf_wen: dec_rf_wen, csr: dec_csr, load: dec_load, store: dec_store};
                // Preload the EXEC countdown so EXEC lasts exactly N cycles.
                if (dec_mul)      cnt_d = MUL_LOAD;
                else if (dec_div) cnt_d = DIV_LOAD;
                else              cnt_d = '0;
                if (!dec_legal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_trap) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ENV;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = (dec_q.load || dec_q.store) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                // An ack always beats a timeout reached in the same cycle.
                if (mem_ack) begin
                    state_d = S_WB;
                end else if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                if (cause_q == CAUSE_ENV) retired_d = retired_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Moore outputs decoded from the current state, all forced low during reset.
    always_comb begin
        ifu_req    = 1'b0;
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        rf_wen     = 1'b0;
        c_wen      = 1'b0;
        pc_wen     = 1'b0;
        trap_vld   = 1'b0;
        trap_cause = 2'b00;
        busy       = 1'b0;
        halted     = 1'b0;
        retired    = '0;
        state_o    = 3'd0;
        if (!rst) begin
            retired = retired_q;
            state_o = state_q;
            busy    = (state_q != S_FETCH) && (state_q != S_HALT);
            case (state_q)
                S_FETCH: ifu_req = 1'b1;
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_wen = dec_q.store;
                end
                S_WB: begin
                    rf_wen = dec_q.rf_wen;
                    c_wen  = dec_q.csr;
                    pc_wen = 1'b1;
                end
                S_TRAP: begin
                    trap_vld   = 1'b1;
                    pc_wen     = 1'b1;
                    trap_cause = cause_q;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed test of control_seq with hand-computed expectations.
module tb_control_seq;

    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             ifu_req, ifu_rdy;
    logic             dec_legal, dec_rf_wen, dec_csr, dec_load, dec_store;
    logic             dec_mul, dec_div, dec_trap, dec_halt;
    logic             mem_req, mem_wen, mem_ack;
    logic             rf_wen, c_wen, pc_wen, trap_vld, busy, halted;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    int total = 0;
    int bad   = 0;

    // Per-instruction tallies filled by run_instr.
    logic [2:0] seq [0:7];
    int n_exec, n_mem, n_memwen, n_rf, n_c, n_pc, n_trap, n_busy, cyc, rf_cyc;
    logic [1:0] last_cause;
    int timed_out;

    control_seq #(
        .MUL_CYCLES (3),
        .DIV_CYCLES (34),
        .MEM_TIMEOUT(8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_req   (ifu_req),
        .ifu_rdy   (ifu_rdy),
        .dec_legal (dec_legal),
        .dec_rf_wen(dec_rf_wen),
        .dec_csr   (dec_csr),
        .dec_load  (dec_load),
        .dec_store (dec_store),
        .dec_mul   (dec_mul),
        .dec_div   (dec_div),
        .dec_trap  (dec_trap),
        .dec_halt  (dec_halt),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_ack   (mem_ack),
        .rf_wen    (rf_wen),
        .c_wen     (c_wen),
        .pc_wen    (pc_wen),
        .trap_vld  (trap_vld),
        .trap_cause(trap_cause),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic legal, input logic rf, input logic csr, input logic ld,
                           input logic st, input logic mul, input logic dv, input logic trp,
                           input logic hlt);
        dec_legal  = legal;
        dec_rf_wen = rf;
        dec_csr    = csr;
        dec_load   = ld;
        dec_store  = st;
        dec_mul    = mul;
        dec_div    = dv;
        dec_trap   = trp;
        dec_halt   = hlt;
    endtask

    // Runs one instruction from FETCH until it returns to FETCH (or reaches HALT).
    // mem_ack is raised on the ack_at-th MEM cycle (0 = never).
    task automatic run_instr(input int ack_at, input int max_cyc);
        int mem_i;
        n_exec = 0; n_mem = 0; n_memwen = 0; n_rf = 0; n_c = 0; n_pc = 0;
        n_trap = 0; n_busy = 0; cyc = 0; rf_cyc = -1; last_cause = 2'b00;
        timed_out = 1; mem_i = 0;
        for (int i = 0; i < 8; i++) seq[i] = 3'd7;
        while (cyc < max_cyc) begin
            ifu_rdy = (state_o == 3'd0);
            mem_ack = (state_o == 3'd3) && (ack_at != 0) && (mem_i + 1 == ack_at);
            if (cyc < 8) seq[cyc] = state_o;
            if ((cyc > 0 && state_o == 3'd0) || state_o == 3'd6) begin
                timed_out = 0;
                break;
            end
            if (state_o == 3'd2) n_exec++;
            if (state_o == 3'd3) begin
                n_mem++;
                mem_i++;
                if (mem_req && mem_wen) n_memwen++;
            end
            if (rf_wen) begin
                n_rf++;
                rf_cyc = cyc;
            end
            if (c_wen)  n_c++;
            if (pc_wen) n_pc++;
            if (busy)   n_busy++;
            if (trap_vld) begin
                n_trap++;
                last_cause = trap_cause;
            end
            step();
            cyc++;
        end
        ifu_rdy = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        int bad_cyc;
        int guard;
        rst = 1'b1;
        ifu_rdy = 1'b1;
        mem_ack = 1'b0;
        set_dec(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset cycle: every output low even though FETCH would raise ifu_req.
        step();
        check("rst_ifu_req", ifu_req, 0);
        check("rst_state", state_o, 0);
        check("rst_busy_pulses", {busy, halted, pc_wen, rf_wen, trap_vld}, 0);
        rst = 1'b0;
        ifu_rdy = 1'b0;
        #1;
        check("post_rst_ifu_req", ifu_req, 1);
        check("post_rst_retired", retired, 0);

        // add: 0,1,2,4,0 with rf_wen only in WB.
        set_dec(1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 50);
        check("add_done", timed_out, 0);
        check("add_seq", {seq[0], seq[1], seq[2], seq[3], seq[4]},
              {3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
        check("add_latency", cyc, 4);
        check("add_rf_cnt", n_rf, 1);
        check("add_rf_cyc", rf_cyc, 3);
        check("add_pc_cnt", n_pc, 1);
        check("add_busy", n_busy, 3);
        check("add_retired", retired, 1);

        // mul: 3 EXEC cycles.
        set_dec(1, 1, 0, 0, 0, 1, 0, 0, 0);
        run_instr(0, 50);
        check("mul_exec", n_exec, 3);
        check("mul_rf_cnt", n_rf, 1);
        check("mul_retired", retired, 2);

        // div: 34 EXEC cycles.
        set_dec(1, 1, 0, 0, 0, 0, 1, 0, 0);
        run_instr(0, 100);
        check("div_done", timed_out, 0);
        check("div_exec", n_exec, 34);
        check("div_rf_cnt", n_rf, 1);
        check("div_retired", retired, 3);

        // lw with ack on the 5th MEM cycle.
        set_dec(1, 1, 0, 1, 0, 0, 0, 0, 0);
        run_instr(5, 50);
        check("lw_mem", n_mem, 5);
        check("lw_memwen", n_memwen, 0);
        check("lw_rf_cnt", n_rf, 1);
        check("lw_trap", n_trap, 0);
        check("lw_retired", retired, 4);

        // sd with no ack: 8 MEM cycles then bus-error trap.
        set_dec(1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_instr(0, 50);
        check("sd_to_mem", n_mem, 8);
        check("sd_to_memwen", n_memwen, 8);
        check("sd_to_trap", n_trap, 1);
        check("sd_to_cause", last_cause, 2'b11);
        check("sd_to_rf", n_rf, 0);
        check("sd_to_pc", n_pc, 1);
        check("sd_to_retired", retired, 4);

        // sd with ack on the timeout cycle: ack wins.
        run_instr(8, 50);
        check("sd_ack_mem", n_mem, 8);
        check("sd_ack_trap", n_trap, 0);
        check("sd_ack_pc", n_pc, 1);
        check("sd_ack_retired", retired, 5);

        // Illegal instruction: trap cause 01, nothing written, not retired.
        set_dec(0, 1, 1, 0, 0, 0, 0, 0, 0);
        run_instr(0, 50);
        check("ill_seq", {seq[0], seq[1], seq[2], seq[3]}, {3'd0, 3'd1, 3'd5, 3'd0});
        check("ill_cause", last_cause, 2'b01);
        check("ill_writes", {n_rf[3:0], n_c[3:0]}, 0);
        check("ill_retired", retired, 5);

        // ecall: trap cause 10, retired.
        set_dec(1, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr(0, 50);
        check("ecall_trap", n_trap, 1);
        check("ecall_cause", last_cause, 2'b10);
        check("ecall_retired", retired, 6);

        // csrrw: c_wen and rf_wen pulses in WB.
        set_dec(1, 1, 1, 0, 0, 0, 0, 0, 0);
        run_instr(0, 50);
        check("csr_c_cnt", n_c, 1);
        check("csr_rf_cnt", n_rf, 1);
        check("csr_retired", retired, 7);

        // ebreak: sticky HALT for 100 cycles, ifu_rdy and mem_ack ignored.
        set_dec(1, 1, 0, 0, 0, 0, 0, 0, 1);
        run_instr(0, 50);
        check("halt_reached", state_o, 6);
        bad_cyc = 0;
        ifu_rdy = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!halted || busy || ifu_req || rf_wen || c_wen || pc_wen || trap_vld || state_o != 3'd6)
                bad_cyc++;
        end
        ifu_rdy = 1'b0;
        mem_ack = 1'b0;
        check("halt_hold", bad_cyc, 0);
        check("halt_retired", retired, 7);
        rst = 1'b1;
        #1;
        check("halt_rst_halted", halted, 0);
        step();
        rst = 1'b0;
        #1;
        check("halt_rst_state", state_o, 0);
        check("halt_rst_ifu_req", ifu_req, 1);
        check("halt_rst_retired", retired, 0);

        // Reset in the middle of a div EXEC: aborted, no commit.
        set_dec(1, 1, 0, 0, 0, 0, 1, 0, 0);
        ifu_rdy = 1'b1;
        guard = 0;
        while (state_o != 3'd2 && guard < 20) begin
            step();
            guard++;
        end
        ifu_rdy = 1'b0;
        check("abort_in_exec", state_o, 2);
        for (int i = 0; i < 5; i++) step();
        check("abort_still_exec", state_o, 2);
        rst = 1'b1;
        #1;
        check("abort_rst_rf", rf_wen, 0);
        step();
        rst = 1'b0;
        #1;
        check("abort_state", state_o, 0);
        check("abort_ifu_req", ifu_req, 1);
        bad_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (rf_wen || pc_wen || state_o != 3'd0) bad_cyc++;
            step();
        end
        check("abort_no_commit", bad_cyc, 0);
        check("abort_retired", retired, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
